// File: rtl/dmem_arb_pkg.sv
// Package: dmem_arb_pkg
// Shared definitions for the data-memory port arbiter:
//   arb_state_e - arbiter FSM state encodings (ST_IDLE / ST_BURST / ST_YIELD)
//   owner_e     - which requester owns an outstanding read (OWN_CORE / OWN_DBG)
//   STATS_W/STATS_MAX - width and saturation value of the optional stall counters
//   cnt_width() - bit width needed to hold a counter value 0..max_val
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_YIELD = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_DBG  = 1'b1
  } owner_e;

  localparam int STATS_W   = 16;
  localparam int STATS_MAX = 65535;

  // Width for a counter that must represent every value from 0 to max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Interface: dmem_port_arbiter_if
// One requester channel into the data-memory arbiter (used for both the core
// load/store path and the debug/loader path).
//   req    requester -> arbiter  access request, held until gnt
//   we     requester -> arbiter  1 = store, 0 = load
//   be     requester -> arbiter  byte enables
//   addr   requester -> arbiter  byte address (AW bits)
//   wdata  requester -> arbiter  store data
//   gnt    arbiter -> requester  request accepted this cycle
//   rvalid arbiter -> requester  load data valid on the shared rd_data bus
// Modports: master = requester side, slave = arbiter side.
interface dmem_port_arbiter_if #(
  parameter int AW = 32
);
  logic          req;
  logic          we;
  logic [3:0]    be;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic          gnt;
  logic          rvalid;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid
  );
endinterface

// File: rtl/dmem_arb_sat_cnt.sv
// Module: dmem_arb_sat_cnt
// Saturating up-counter with synchronous clear.
//   clk   in   clock
//   rst_n in   asynchronous active-low reset (count -> 0)
//   inc   in   increment by one unless already at MAX
//   clr   in   clear to zero; takes priority over inc
//   cnt   out  current count (WIDTH bits)
module dmem_arb_sat_cnt #(
  parameter int WIDTH = 4,
  parameter int MAX   = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX_V)) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Module: dmem_port_arbiter
// Arbitrates the single data-memory port between the core load/store path
// and a debug/loader requester. Grants are combinational from the requests,
// the FSM state and the starvation/burst counters; at most one grant per
// cycle. Read data returns one cycle after issue and is steered to the side
// that issued the read. Debug may lock the port for bounded bursts; a
// starvation guard lets a blocked debug requester override core priority.
//
// Parameters:
//   AW            byte address width
//   MAX_BURST     max consecutive debug grants under dbg_lock before the core gets a slot
//   STARVE_LIMIT  cycles a blocked debug request waits before overriding core priority
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   core_if (slave)     core request channel  (req/we/be/addr/wdata -> gnt/rvalid)
//   dbg_if  (slave)     debug request channel (req/we/be/addr/wdata -> gnt/rvalid)
//   dbg_lock            hold debug ownership across consecutive requests
//   rd_data             read data for whichever side has rvalid (0 otherwise)
//   mem_en/we/be/addr/wdata  dmem request, taken from the granted side, 0 when idle
//   mem_rdata           dmem read data, valid the cycle after a read issue
// Optional build macro DMEM_ARB_STATS_EN adds:
//   core_stall_cnt, dbg_stall_cnt  saturating counts of cycles with req & !gnt
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW           = 32,
  parameter int MAX_BURST    = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  dmem_port_arbiter_if.slave        core_if,
  dmem_port_arbiter_if.slave        dbg_if,
  input  logic                      dbg_lock,
  output logic [31:0]               rd_data,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [3:0]                mem_be,
  output logic [AW-1:0]             mem_addr,
  output logic [31:0]               mem_wdata,
  input  logic [31:0]               mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [STATS_W-1:0]        core_stall_cnt,
  output logic [STATS_W-1:0]        dbg_stall_cnt
`endif
);

  localparam int BW = cnt_width(MAX_BURST);
  localparam int SW = cnt_width(STARVE_LIMIT);

  localparam logic [BW-1:0] BURST_MAX_V    = BW'(MAX_BURST);
  localparam logic [BW-1:0] BURST_PENULT_V = BW'(MAX_BURST - 1);
  localparam logic [SW-1:0] STARVE_MAX_V   = SW'(STARVE_LIMIT);

  arb_state_e      state_reg;
  arb_state_e      state_next;
  logic [BW-1:0]   burst_cnt;
  logic [SW-1:0]   starve_cnt;
  logic            rd_pend_q;
  owner_e          owner_q;

  logic            core_gnt_arb;
  logic            dbg_gnt_arb;
  logic            core_gnt;
  logic            dbg_gnt;
  logic            starve_full;
  logic            burst_at_max;
  logic            burst_hit;
  logic [1:0]      rvalid_vec;

  assign starve_full  = (starve_cnt == STARVE_MAX_V);
  assign burst_at_max = (burst_cnt == BURST_MAX_V);
  // The burst is exhausted either already, or by the debug grant being
  // given this very cycle; the latter lets the core slot follow the last
  // debug beat without an idle cycle in between.
  assign burst_hit    = burst_at_max || (dbg_gnt && (burst_cnt == BURST_PENULT_V));

  // ---------------------------------------------------------------------
  // Grant selection
  // ---------------------------------------------------------------------
  always_comb begin
    core_gnt_arb = 1'b0;
    dbg_gnt_arb  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // Core has priority unless debug has waited out the starvation limit.
        if (dbg_if.req && (!core_if.req || starve_full)) begin
          dbg_gnt_arb = 1'b1;
        end else begin
          core_gnt_arb = core_if.req;
        end
      end
      ST_BURST: begin
        // Debug has priority, but a full burst never grows past MAX_BURST
        // while the core is waiting.
        if (dbg_if.req && !(burst_at_max && core_if.req)) begin
          dbg_gnt_arb = 1'b1;
        end else begin
          core_gnt_arb = core_if.req;
        end
      end
      ST_YIELD: begin
        core_gnt_arb = core_if.req;
      end
      default: begin
        core_gnt_arb = 1'b0;
        dbg_gnt_arb  = 1'b0;
      end
    endcase
  end

  // The port is held idle for as long as reset is asserted, even though
  // grants are otherwise a combinational function of the requests.
  assign core_gnt = core_gnt_arb & rst_n;
  assign dbg_gnt  = dbg_gnt_arb & rst_n;

  assign core_if.gnt = core_gnt;
  assign dbg_if.gnt  = dbg_gnt;

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (dbg_gnt && dbg_lock) begin
          state_next = ST_BURST;
        end
      end
      ST_BURST: begin
        if (!dbg_lock) begin
          state_next = ST_IDLE;
        end else if (core_if.req && burst_hit) begin
          state_next = ST_YIELD;
        end
      end
      ST_YIELD: begin
        state_next = dbg_lock ? ST_BURST : ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM state and read-return tracking
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      rd_pend_q <= 1'b0;
      owner_q   <= OWN_CORE;
    end else begin
      state_reg <= state_next;
      rd_pend_q <= (core_gnt & ~core_if.we) | (dbg_gnt & ~dbg_if.we);
      if (core_gnt || dbg_gnt) begin
        owner_q <= dbg_gnt ? OWN_DBG : OWN_CORE;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Counters
  // ---------------------------------------------------------------------
  dmem_arb_sat_cnt #(
    .WIDTH (SW),
    .MAX   (STARVE_LIMIT)
  ) u_starve_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (dbg_if.req & ~dbg_gnt),
    .clr   (dbg_gnt | ~dbg_if.req),
    .cnt   (starve_cnt)
  );

  // Counts debug grants within the current burst segment. Any cycle that
  // does not end in ST_BURST clears it, so entry to ST_IDLE/ST_YIELD always
  // starts from zero, and the IDLE->BURST grant lands as the first beat.
  dmem_arb_sat_cnt #(
    .WIDTH (BW),
    .MAX   (MAX_BURST)
  ) u_burst_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (dbg_gnt),
    .clr   (state_next != ST_BURST),
    .cnt   (burst_cnt)
  );

  // ---------------------------------------------------------------------
  // Read-return steering: index 0 = core, 1 = debug
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_rvalid
    assign rvalid_vec[gi] = rd_pend_q && (owner_q == ((gi == 0) ? OWN_CORE : OWN_DBG));
  end

  assign core_if.rvalid = rvalid_vec[0];
  assign dbg_if.rvalid  = rvalid_vec[1];
  assign rd_data        = rd_pend_q ? mem_rdata : 32'h0;

  // ---------------------------------------------------------------------
  // Memory request mux
  // ---------------------------------------------------------------------
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'h0;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    if (core_gnt) begin
      mem_en    = 1'b1;
      mem_we    = core_if.we;
      mem_be    = core_if.be;
      mem_addr  = core_if.addr;
      mem_wdata = core_if.wdata;
    end else if (dbg_gnt) begin
      mem_en    = 1'b1;
      mem_we    = dbg_if.we;
      mem_be    = dbg_if.be;
      mem_addr  = dbg_if.addr;
      mem_wdata = dbg_if.wdata;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  // ---------------------------------------------------------------------
  // Stall statistics: index 0 = core, 1 = debug
  // ---------------------------------------------------------------------
  logic [1:0]         req_vec;
  logic [1:0]         gnt_vec;
  logic [STATS_W-1:0] stall_cnt [2];

  assign req_vec = {dbg_if.req, core_if.req};
  assign gnt_vec = {dbg_gnt, core_gnt};

  for (genvar gi = 0; gi < 2; gi++) begin : g_stall
    dmem_arb_sat_cnt #(
      .WIDTH (STATS_W),
      .MAX   (STATS_MAX)
    ) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (req_vec[gi] & ~gnt_vec[gi]),
      .clr   (1'b0),
      .cnt   (stall_cnt[gi])
    );
  end

  assign core_stall_cnt = stall_cnt[0];
  assign dbg_stall_cnt  = stall_cnt[1];
`endif

endmodule
